// File: rtl/sync_fifo_pkg.sv
// Shared constants and types for the parametrised synchronous FIFO.
package sync_fifo_pkg;

  localparam int DEF_DATA_W = 128;
  localparam int DEF_DEPTH  = 16;
  localparam int DEF_PTR_W  = $clog2(DEF_DEPTH);

  // Count needs one bit more than a pointer so that DEPTH itself is representable.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int DEF_CNT_W = cnt_width(DEF_DEPTH);

  typedef struct packed {
    logic [DEF_PTR_W-1:0] wr_ptr;
    logic [DEF_PTR_W-1:0] rd_ptr;
    logic [DEF_CNT_W-1:0] count;
  } fifo_state_t;

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage array: one write port, one registered read port.
module sync_fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto RAM; only the output register is cleared.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // NOTE: non-blocking assignments for every flop, so edge-ordering between blocks never matters.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with programmable almost-full/almost-empty thresholds.
// Define SYNC_FIFO_ERR_EN to add sticky o_overflow/o_underflow flags and i_clr_err.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int CNT_W  = cnt_width(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_wren,
  input  logic [DATA_W-1:0] i_wrdata,
  input  logic              i_rden,
  output logic [DATA_W-1:0] o_rddata,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_alm_full,
  output logic              o_alm_empty,
  input  logic [CNT_W-1:0]  i_alm_full_th,
  input  logic [CNT_W-1:0]  i_alm_empty_th,
`ifdef SYNC_FIFO_ERR_EN
  output logic              o_overflow,
  output logic              o_underflow,
  input  logic              i_clr_err,
`endif
  output logic [CNT_W-1:0]  o_count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             wr_acc;
  logic             rd_acc;

  assign o_count     = count;
  assign o_full      = (count == CNT_W'(DEPTH));
  assign o_empty     = (count == '0);
  assign o_alm_full  = (count >= i_alm_full_th);
  assign o_alm_empty = (count <= i_alm_empty_th);
  assign wr_acc      = i_wren & ~o_full;
  assign rd_acc      = i_rden & ~o_empty;

  always_comb begin
    // NOTE: default assigned first so no path through the case can infer a latch.
    count_nxt = count;
    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_acc) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
    end
  end

  sync_fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (i_wrdata),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr),
    .rd_data (o_rddata)
  );

`ifdef SYNC_FIFO_ERR_EN
  // A clear in the same cycle as an offending request wins.
  always_ff @(posedge clk) begin
    if (reset || i_clr_err) begin
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      o_overflow  <= o_overflow  | (i_wren & o_full);
      o_underflow <= o_underflow | (i_rden & o_empty);
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: queue-based reference model plus directed scenarios.
module tb_sync_fifo_param;
  import sync_fifo_pkg::*;

  localparam int DW = 128;
  localparam int DP = 16;
  localparam int CW = cnt_width(DP);

  logic          clk;
  logic          reset;
  logic          wren;
  logic [DW-1:0] wrdata;
  logic          rden;
  logic [DW-1:0] rddata;
  logic          full, empty, alm_full, alm_empty;
  logic [CW-1:0] alm_full_th, alm_empty_th, count;
  logic          clr_err;
`ifdef SYNC_FIFO_ERR_EN
  logic          overflow, underflow;
`endif

  int n_checks = 0;
  int n_errors = 0;

  sync_fifo_param #(.DATA_W(DW), .DEPTH(DP)) dut (
    .clk            (clk),
    .reset          (reset),
    .i_wren         (wren),
    .i_wrdata       (wrdata),
    .i_rden         (rden),
    .o_rddata       (rddata),
    .o_full         (full),
    .o_empty        (empty),
    .o_alm_full     (alm_full),
    .o_alm_empty    (alm_empty),
    .i_alm_full_th  (alm_full_th),
    .i_alm_empty_th (alm_empty_th),
`ifdef SYNC_FIFO_ERR_EN
    .o_overflow     (overflow),
    .o_underflow    (underflow),
    .i_clr_err      (clr_err),
`endif
    .o_count        (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: a queue of words, evaluated on the falling edge.
  // Outputs are compared first, then the model advances using the inputs the next rising edge will sample.
  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_rd;
  logic          exp_ovf, exp_unf;
  fifo_state_t   mon;
  bit            armed = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (armed) begin
        mon.count = CW'(q.size());
        check("m_count",     count,     mon.count);
        check("m_full",      full,      q.size() == DP);
        check("m_empty",     empty,     q.size() == 0);
        check("m_alm_full",  alm_full,  mon.count >= alm_full_th);
        check("m_alm_empty", alm_empty, mon.count <= alm_empty_th);
        check("m_rddata",    rddata,    exp_rd);
`ifdef SYNC_FIFO_ERR_EN
        check("m_overflow",  overflow,  exp_ovf);
        check("m_underflow", underflow, exp_unf);
`endif
      end
      if (reset) begin
        q.delete();
        exp_rd  = '0;
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
        mon     = '0;
        armed   = 1;
      end else if (armed) begin
        automatic bit is_full  = (q.size() == DP);
        automatic bit is_empty = (q.size() == 0);
        exp_ovf = clr_err ? 1'b0 : (exp_ovf | (wren & is_full));
        exp_unf = clr_err ? 1'b0 : (exp_unf | (rden & is_empty));
        if (rden && !is_empty) begin
          exp_rd = q.pop_front();
          mon.rd_ptr = mon.rd_ptr + 1'b1;
        end
        if (wren && !is_full) begin
          q.push_back(wrdata);
          mon.wr_ptr = mon.wr_ptr + 1'b1;
        end
      end
    end
  end

  // Apply one cycle of stimulus (called just after a rising edge); returns just after the next edge.
  task automatic step(input logic we, input logic [DW-1:0] wd, input logic re);
    wren = we; wrdata = wd; rden = re;
    @(posedge clk); #1;
    wren = 1'b0; rden = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; wren = 1'b0; rden = 1'b0; wrdata = '0; clr_err = 1'b0;
    alm_full_th = CW'(14); alm_empty_th = CW'(2);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state, idle
    step(0, '0, 0);
    check("rst_empty",     empty,     1'b1);
    check("rst_full",      full,      1'b0);
    check("rst_alm_empty", alm_empty, 1'b1);
    check("rst_alm_full",  alm_full,  1'b0);
    check("rst_count",     count,     '0);
    check("rst_rddata",    rddata,    '0);

    // Fill to full, then one dropped write
    for (int i = 1; i <= 16; i++) begin
      step(1, DW'(i), 0);
      check("fill_alm_full", alm_full, (i >= 14));
    end
    check("fill_full",  full,  1'b1);
    check("fill_count", count, 16);
    step(1, 'hFF, 0);
    check("ovf_count", count, 16);
`ifdef SYNC_FIFO_ERR_EN
    check("ovf_flag", overflow, 1'b1);
`endif

    // Drain in order, then one read while empty
    for (int i = 1; i <= 16; i++) begin
      step(0, '0, 1);
      check("drain_data", rddata, DW'(i));
    end
    check("drain_empty", empty, 1'b1);
    step(0, '0, 1);
    check("unf_hold", rddata, 'h10);
`ifdef SYNC_FIFO_ERR_EN
    check("unf_flag", underflow, 1'b1);
    clr_err = 1'b1;
    step(0, '0, 1);
    clr_err = 1'b0;
    check("clr_ovf", overflow, 1'b0);
    check("clr_unf", underflow, 1'b0);
`endif

    // Fill to 8, then 40 cycles of simultaneous read/write across pointer wrap
    for (int i = 0; i < 8; i++) step(1, DW'('h100 + i), 0);
    for (int k = 0; k < 40; k++) begin
      step(1, DW'('h200 + k), 1);
      check("stream_count", count, 8);
      check("stream_data", rddata, (k < 8) ? DW'('h100 + k) : DW'('h200 + k - 8));
    end

    // Top up to full, then read+write together while full
    for (int i = 0; i < 8; i++) step(1, DW'('h300 + i), 0);
    check("full2", full, 1'b1);
    step(1, 'hAA, 1);
    check("fullrw_count", count, 15);
    check("fullrw_data",  rddata, 'h220);
    for (int i = 0; i < 15; i++) step(0, '0, 1);
    check("drain2_last", rddata, 'h307);
    check("drain2_empty", empty, 1'b1);

    // Read+write together while empty
    step(1, 'hBB, 1);
    check("emptyrw_count", count, 1);
    check("emptyrw_hold",  rddata, 'h307);
    step(0, '0, 1);
    check("emptyrw_data", rddata, 'hBB);

    // Threshold boundary: zero almost-full threshold
    alm_full_th = '0;
    step(0, '0, 0);
    check("th0_alm_full", alm_full, 1'b1);
    alm_full_th = CW'(14);

    // Almost-empty threshold at DEPTH, then reset mid-stream
    alm_empty_th = CW'(16);
    for (int i = 0; i < 5; i++) step(1, DW'('h400 + i), 0);
    check("thD_alm_empty", alm_empty, 1'b1);
    alm_empty_th = CW'(2);
    step(0, '0, 0);
    check("th2_alm_empty", alm_empty, 1'b0);
    check("pre_rst_count", count, 5);
    reset = 1'b1;
    step(0, '0, 0);
    reset = 1'b0;
    check("mid_rst_count",  count,     '0);
    check("mid_rst_empty",  empty,     1'b1);
    check("mid_rst_rddata", rddata,    '0);
    check("mid_rst_alm_e",  alm_empty, 1'b1);
    step(1, 'h500, 0);
    step(0, '0, 1);
    check("post_rst_data",  rddata, 'h500);
    check("post_rst_count", count,  '0);

    step(0, '0, 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
